// File: rtl/count_updn_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_updn_mod                                                             |
// | Up/down modulo counter: parallel load, terminal count, wrap pulse.          |
// | COUNT_UPDN_SAT_EN defined: saturate at the limits instead of wrapping.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module count_updn_mod #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] CNT_In,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

`ifdef COUNT_UPDN_SAT_EN
  localparam bit c_SATURATE = 1'b1;
`else
  localparam bit c_SATURATE = 1'b0;
`endif

  generate
    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
      $error("count_updn_mod: WIDTH must be within 2..32");
    end
    if ((MAX < 1) || (64'(MAX) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_max
      $error("count_updn_mod: MAX must be within 1..2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_limit_next;

  assign w_at_max   = (cnt_q == c_MAX);
  assign w_at_zero  = (cnt_q == c_ZERO);
  assign w_load_val = (CNT_In > c_MAX) ? c_MAX : CNT_In;

  // At a limit: saturation holds the count, wrap mode jumps to the opposite end.
  assign w_limit_next = c_SATURATE ? cnt_q : (up ? c_ZERO : c_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = w_load_val;
    end else if (EN) begin
      if (up) begin
        if (w_at_max) begin
          cnt_d  = w_limit_next;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end else begin
        if (w_at_zero) begin
          cnt_d  = w_limit_next;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - c_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q  <= c_ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // TC is the cascade enable for a following stage, so it follows up without delay.
  assign TC   = up ? w_at_max : w_at_zero;
  assign CNT  = cnt_q;
  assign WRAP = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_count_updn_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_count_updn_mod                                                          |
// | Scoreboard bench: 8-bit default and 4-bit MAX=9 counters vs. a model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_count_updn_mod;

`ifdef COUNT_UPDN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic       en8, ld8, up8;
  logic [7:0] in8;
  logic [7:0] cnt8;
  logic       tc8, wrap8;
  logic       en4, ld4, up4;
  logic [3:0] in4;
  logic [3:0] cnt4;
  logic       tc4, wrap4;

  always #5 clk = ~clk;

  count_updn_mod dut8 (
    .clk(clk), .res(res), .EN(en8), .load(ld8), .up(up8), .CNT_In(in8),
    .CNT(cnt8), .TC(tc8), .WRAP(wrap8)
  );

  count_updn_mod #(.WIDTH(4), .MAX(9)) dut4 (
    .clk(clk), .res(res), .EN(en4), .load(ld4), .up(up4), .CNT_In(in4),
    .CNT(cnt4), .TC(tc4), .WRAP(wrap4)
  );

  typedef struct {
    int cnt8; bit wrap8; bit tc8;
    int cnt4; bit wrap4; bit tc4;
  } exp_t;

  exp_t q[$];
  int   m8 = 0;
  int   m4 = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: modular arithmetic in wrap mode, clamping in saturate mode.
  function automatic void model(input bit rs, input bit ld, input bit en, input bit u,
                                input int din, input int mx, input int cur,
                                output int nxt, output bit wr);
    nxt = cur;
    wr  = 1'b0;
    if (rs) begin
      nxt = 0;
    end else if (ld) begin
      nxt = (din > mx) ? mx : din;
    end else if (en) begin
      wr = u ? (cur == mx) : (cur == 0);
      if (SAT) begin
        nxt = u ? cur + 1 : cur - 1;
        if (nxt > mx) nxt = mx;
        if (nxt < 0)  nxt = 0;
      end else begin
        nxt = u ? (cur + 1) % (mx + 1) : (cur + mx) % (mx + 1);
      end
    end
  endfunction

  task automatic step();
    exp_t e;
    int   n8, n4;
    bit   w8, w4;
    model(res, ld8, en8, up8, int'(in8), 255, m8, n8, w8);
    model(res, ld4, en4, up4, int'(in4), 9,   m4, n4, w4);
    m8 = n8;
    m4 = n4;
    e.cnt8 = n8; e.wrap8 = w8; e.tc8 = up8 ? (n8 == 255) : (n8 == 0);
    e.cnt4 = n4; e.wrap4 = w4; e.tc4 = up4 ? (n4 == 9)   : (n4 == 0);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cnt8",  int'(cnt8),  e.cnt8);
        chk("wrap8", int'(wrap8), int'(e.wrap8));
        chk("tc8",   int'(tc8),   int'(e.tc8));
        chk("cnt4",  int'(cnt4),  e.cnt4);
        chk("wrap4", int'(wrap4), int'(e.wrap4));
        chk("tc4",   int'(tc4),   int'(e.tc4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1;
    en8 = 1'b0; ld8 = 1'b0; up8 = 1'b1; in8 = '0;
    en4 = 1'b0; ld4 = 1'b0; up4 = 1'b1; in4 = '0;
    @(negedge clk);

    repeat (3) step();
    res = 1'b0; en8 = 1'b1; up8 = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the low phase, checked before the next edge.
    #2 res = 1'b1;
    #1;
    chk("async_rst_cnt8", int'(cnt8), 0);
    chk("async_rst_cnt4", int'(cnt4), 0);
    m8 = 0;
    m4 = 0;
    step();
    res = 1'b0;

    ld8 = 1'b1; in8 = 8'h11; en8 = 1'b1;
    step();
    ld8 = 1'b0;
    repeat (2) step();
    en8 = 1'b0;
    repeat (5) step();
    en8 = 1'b1;
    step();

    ld4 = 1'b1; in4 = 4'd8; en4 = 1'b1; up4 = 1'b1;
    step();
    ld4 = 1'b0;
    repeat (3) step();

    ld4 = 1'b1; in4 = 4'hF;
    step();
    ld4 = 1'b0; up4 = 1'b0;
    repeat (11) step();

    ld8 = 1'b1; in8 = 8'hFE; en8 = 1'b1; up8 = 1'b1;
    step();
    ld8 = 1'b0;
    repeat (3) step();
    up8 = 1'b0;
    step();

    ld8 = 1'b1; in8 = 8'hFF;
    step();
    in8 = 8'h05; en8 = 1'b1; up8 = 1'b1;
    step();

    in8 = 8'h80;
    step();
    ld8 = 1'b0; up8 = 1'b1;
    step();
    up8 = 1'b0;
    step();
    up8 = 1'b1;
    step();

    for (int i = 0; i < 400; i++) begin
      res = ($urandom_range(0, 63) == 0);
      ld8 = ($urandom_range(0, 7) == 0);
      en8 = ($urandom_range(0, 3) != 0);
      up8 = $urandom_range(0, 1) != 0;
      in8 = 8'($urandom_range(0, 255));
      ld4 = ($urandom_range(0, 7) == 0);
      en4 = ($urandom_range(0, 3) != 0);
      up4 = $urandom_range(0, 1) != 0;
      in4 = 4'($urandom_range(0, 15));
      step();
    end

    res = 1'b0; ld8 = 1'b0; ld4 = 1'b0; en8 = 1'b0; en4 = 1'b0;
    step();
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
